ste_avg_bcd_conv: RTL
=====================

// Module: ste_avg_bcd_conv
// PURPOSE
//  Consumes the averager's output stream (data word + one-cycle update strobe) and converts each
//  accepted unsigned binary word to packed BCD for the multimeter 7-segment display path.
//  Uses a sequential shift-add-3 (double-dabble) engine: one bit per clock.
//  Has a one-deep pending slot, a display-hold freeze and overflow saturation.
//  Sits between the averaging stage and the digit multiplexer/segment decoder.
// PARAMETERS
//  DATA_W   16  width of input binary word (unsigned)
//  DIGITS   5   number of BCD output digits (4 bits each)
// PORTS
//  clk           in   1          system clock, single clock domain
//  rst           in   1          synchronous reset, active-high
//  din_i         in   DATA_W     averaged binary value
//  din_update_i  in   1          one-cycle strobe: din_i is valid this cycle
//  hold_i        in   1          display hold: 1 = freeze outputs, ignore new updates
//  bcd_o         out  4*DIGITS   packed BCD; digit 0 = bcd_o[3:0] (LSD)
//  bcd_valid_o   out  1          one-cycle pulse: bcd_o/ovf_o just updated
//  busy_o        out  1          conversion in progress
//  ovf_o         out  1          value > 10^DIGITS-1; bcd_o saturated to all 9s
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; bcd_o=0; bcd_valid_o=0; busy_o=0; ovf_o=0.
//   Pending slot is cleared. rst mid-conversion aborts immediately; no bcd_valid_o pulse.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: if din_update_i && !hold_i, load shift reg = din_i, scratch BCD = 0,
//    bit counter = DATA_W-1, ovf scratch = 0; go to SHIFT.
//    Else, if pending slot valid && !hold_i, load from pending; go to SHIFT.
//   SHIFT, each cycle:
//    - every scratch digit >= 5 gets +3;
//    - shift {bcd, sreg} left by 1;
//    - a 1 shifted out of the top digit sets ovf scratch (sticky);
//    - at counter==0 go to DONE, else decrement.
//    Exactly DATA_W cycles in SHIFT.
//   DONE: bcd_o <= ovf ? all 4'h9 : scratch; ovf_o <= ovf; bcd_valid_o=1 for this one cycle;
//    go to IDLE.
//  Latency: strobe at cycle N (IDLE) -> bcd_valid_o high at cycle N+DATA_W+1 (registered).
//   Default: 17 cycles.
//  busy_o = 1 in SHIFT and DONE.
//  Throughput: next load is possible in the IDLE cycle after DONE.
//  Update while busy_o=1: din_i is stored in the pending slot.
//   A newer strobe overwrites the older one: latest value wins, no queueing.
//  Update in the DONE cycle: it goes to pending, same as any update while busy.
//  IDLE with both a strobe and a valid pending slot: the strobe wins and pending is cleared.
//  hold_i=1:
//   - strobes are dropped and the pending slot is cleared;
//   - bcd_o/ovf_o stay frozen and bcd_valid_o stays 0;
//   - a conversion already in SHIFT runs to completion, but DONE does not update outputs.
//   Releasing hold_i does not re-convert. The next strobe is needed.
//  Arithmetic: digit compare/add is 4-bit unsigned. Scratch width = 4*DIGITS.
//   No overflow is possible when DIGITS*log2(10) >= DATA_W.
//  Strobe in the same cycle as rst=1: ignored.
// CONFIGURATION
//  Macro STE_BCD_BLANK_EN:
//   - Defined: in DONE, leading zero digits above the most significant nonzero digit become
//     4'hF (blank code for the segment decoder). Digit 0 is never blanked, so value 0 -> ...FFF0.
//     No blanking when ovf is set.
//   - Undefined: leading zeros are output as 4'h0. Outputs are unchanged otherwise.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; busy_o=0.
//  2. din_i=16'd12345, strobe 1 cycle -> busy_o 1 for 17 cycles;
//     bcd_o=20'h12345 and bcd_valid_o pulse at +17; ovf_o=0.
//  3. DIGITS=4, din_i=16'd10000 -> bcd_o=16'h9999, ovf_o=1.
//     Then din_i=16'd9999 -> bcd_o=16'h9999, ovf_o=0.
//  4. Strobes 100, then 200, then 300 while busy -> two results: 0x00100, then 0x00300.
//     200 is lost. Exactly 2 bcd_valid_o pulses.
//  5. hold_i=1, strobe 555 -> no pulse, bcd_o unchanged.
//     Release hold_i, strobe 7 -> bcd_o=0x00007
//     (0xFFFF7 with STE_BCD_BLANK_EN; value 0 -> 0xFFFF0).
//  6. rst=1 at SHIFT cycle 5 -> no pulse, outputs 0.
//     A strobe afterwards converts correctly.

Source files
------------

// File: rtl/ste_avg_bcd_conv.sv
// Sequential double-dabble converter from averaged binary words to packed BCD for the display.
// Optional macro STE_BCD_BLANK_EN replaces leading zero digits with the 4'hF blank code.
module ste_avg_bcd_conv #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din_i,
    input  logic                  din_update_i,
    input  logic                  hold_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_scr_q, ovf_scr_d;
    logic                pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                bcd_valid_q, bcd_valid_d;
    logic                ovf_q, ovf_d;

    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    sat;
    logic [BCD_W-1:0]    result;
`ifdef STE_BCD_BLANK_EN
    logic                seen;
`endif

    // Add-3 correction on every digit that would reach 10 or more after the shift.
    always_comb begin
        adj = '0;
        sat = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                          : scratch_q[4*i +: 4];
            sat[4*i +: 4] = 4'h9;
        end
    end

    always_comb begin
        result = ovf_scr_q ? sat : scratch_q;
`ifdef STE_BCD_BLANK_EN
        seen = ovf_scr_q;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (!seen && scratch_q[4*i +: 4] == 4'h0) begin
                result[4*i +: 4] = 4'hF;
            end else begin
                seen = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        ovf_scr_d    = ovf_scr_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        bcd_d        = bcd_q;
        bcd_valid_d  = 1'b0;
        ovf_d        = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (din_update_i && !hold_i) begin
                    sreg_d       = din_i;
                    scratch_d    = '0;
                    cnt_d        = CNT_LAST;
                    ovf_scr_d    = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = StShift;
                end else if (pend_valid_q && !hold_i) begin
                    sreg_d       = pend_data_q;
                    scratch_d    = '0;
                    cnt_d        = CNT_LAST;
                    ovf_scr_d    = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                sreg_d    = {sreg_q[DATA_W-2:0], 1'b0};
                scratch_d = {adj[BCD_W-2:0], sreg_q[DATA_W-1]};
                ovf_scr_d = ovf_scr_q | adj[BCD_W-1];
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (!hold_i) begin
                    bcd_d       = result;
                    ovf_d       = ovf_scr_q;
                    bcd_valid_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Latest strobe while busy wins; hold flushes anything waiting.
        if (state_q != StIdle && din_update_i && !hold_i) begin
            pend_valid_d = 1'b1;
            pend_data_d  = din_i;
        end
        if (hold_i) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            ovf_scr_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            bcd_q        <= '0;
            bcd_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            ovf_scr_q    <= ovf_scr_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            bcd_q        <= bcd_d;
            bcd_valid_q  <= bcd_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = bcd_valid_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != StIdle);

endmodule
